// File: rtl/npu_host_pkg.sv
// Shared types and constants for the NPU host-port bus initiator.
package npu_host_pkg;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [2:0] {
    OP_WR_IMG     = 3'd0,
    OP_WR_W       = 3'd1,
    OP_WR_FCN     = 3'd2,
    OP_CTRL       = 3'd3,
    OP_RD_DONE    = 3'd4,
    OP_RD_RESULT  = 3'd5,
    OP_POLL_VALID = 3'd6,
    OP_POLL_DONE  = 3'd7
  } op_e;

  // Register select values placed in addra[14:12].
  localparam logic [2:0] SEL_IMG    = 3'd1;
  localparam logic [2:0] SEL_W      = 3'd2;
  localparam logic [2:0] SEL_FCN    = 3'd3;
  localparam logic [2:0] SEL_CTRL   = 3'd4;
  localparam logic [2:0] SEL_DONE   = 3'd5;
  localparam logic [2:0] SEL_RESULT = 3'd6;
  localparam logic [2:0] SEL_VALID  = 3'd7;

  // Bit positions inside the NPU CTRL register.
  localparam int CTRL_TRIGGER    = 0;
  localparam int CTRL_NEXT_STATE = 1;
  localparam int CTRL_PE_CLEAR   = 2;
  localparam int CTRL_IMG_CLEAR  = 3;
  localparam int CTRL_W_CLEAR    = 4;
  localparam int CTRL_PACK_CLEAR = 5;

  // Initiator FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

  // Opcode to register select.
  function automatic logic [2:0] op_sel(input op_e op);
    case (op)
      OP_WR_IMG:     return SEL_IMG;
      OP_WR_W:       return SEL_W;
      OP_WR_FCN:     return SEL_FCN;
      OP_CTRL:       return SEL_CTRL;
      OP_RD_DONE:    return SEL_DONE;
      OP_RD_RESULT:  return SEL_RESULT;
      OP_POLL_VALID: return SEL_VALID;
      OP_POLL_DONE:  return SEL_DONE;
      default:       return SEL_IMG;
    endcase
  endfunction

  // Opcodes 0..3 are single writes.
  function automatic logic op_is_write(input op_e op);
    return (op == OP_WR_IMG) || (op == OP_WR_W) ||
           (op == OP_WR_FCN) || (op == OP_CTRL);
  endfunction

  // Opcodes 6..7 spin on flag bit 0.
  function automatic logic op_is_poll(input op_e op);
    return (op == OP_POLL_VALID) || (op == OP_POLL_DONE);
  endfunction

endpackage

// File: rtl/npu_host_master.sv
// Bus initiator turning a command stream into NPU host-port transactions.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. cmd_ready depends only on the
// state (high in IDLE), rsp_valid/rsp_data/rsp_err stay stable until taken.
module npu_host_master
  import npu_host_pkg::*;
#(
  parameter int POLL_MAX = 1023,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output state_e            dbg_state
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);

  state_e            state_q, state_d;
  logic              ena_q, ena_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              poll_q, poll_d;
  op_e               op_in;

  assign op_in = op_e'(cmd_op);

  // Next-state and next-output decode; every bus cycle is followed by an idle one.
  always_comb begin
    state_d     = state_q;
    ena_d       = 1'b0;
    wea_d       = 1'b0;
    addra_d     = addra_q;
    dina_d      = dina_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_d   = '0;
          poll_d  = op_is_poll(op_in);
          addra_d = ADDR_W'({1'b0, op_sel(op_in), 12'h000});
          ena_d   = 1'b1;
          if (op_is_write(op_in)) begin
            state_d = ST_WR;
            wea_d   = 1'b1;
            dina_d  = cmd_data;
          end else begin
            state_d = ST_RD;
            dina_d  = '0;
          end
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        // douta holds the slave's registered read data in this cycle.
        if (!poll_q || douta[0]) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = douta;
          rsp_err_d   = 1'b0;
        end else if (cnt_q != POLL_LIM) begin
          state_d = ST_RD;
          cnt_d   = cnt_q + CNT_W'(1);
          ena_d   = 1'b1;
        end else begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = douta;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      poll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ena       = ena_q;
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_npu_host_master.sv
// Directed bench for npu_host_master with a small NPU host-port slave model.
module tb_npu_host_master;
  import npu_host_pkg::*;

  localparam int POLL_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        ena;
  logic        wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta = 32'h0;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  npu_host_master #(.POLL_MAX(POLL_MAX), .ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .dbg_state(dbg_state)
  );

  // Slave model: registered read data from a queue, CTRL pulse bits
  // cleared on any cycle without an access.
  logic [31:0] rd_q[$];
  logic [5:0]  ctrl_q = 6'h0;
  logic        trigger;
  assign trigger = ctrl_q[CTRL_TRIGGER];

  always @(posedge clk) begin
    if (ena && wea && addra[14:12] == SEL_CTRL) ctrl_q <= dina[5:0];
    else if (!ena) ctrl_q <= 6'h0;
    if (ena && !wea) begin
      if (rd_q.size() > 0) douta <= rd_q.pop_front();
      else douta <= 32'h0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for IDLE, presents one command for one edge.
  task automatic issue(input op_e op, input logic [31:0] data);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({ena, wea, addra, dina, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ena=%b wea=%b addra=%h dina=%h rv=%b rd=%h re=%b busy=%b exp all 0",
               ena, wea, addra, dina, rsp_valid, rsp_data, rsp_err, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_release got ready=%b busy=%b st=%0d exp 1 0 0",
               cmd_ready, busy, dbg_state);
    end
  endtask

  task automatic test_write_img();
    issue(OP_WR_IMG, 32'h0003_0201);
    checks++;
    if (ena !== 1'b1 || wea !== 1'b1 || addra !== 16'h1000 || dina !== 32'h0003_0201) begin
      errors++;
      $display("FAIL wr_img_bus got ena=%b wea=%b addra=%h dina=%h exp 1 1 1000 00030201",
               ena, wea, addra, dina);
    end
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_img_busy got ready=%b busy=%b exp 0 1", cmd_ready, busy);
    end
    step();
    checks++;
    if (ena !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_img_after got ena=%b ready=%b rv=%b exp 0 1 0",
               ena, cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    issue(OP_CTRL, 32'h0000_0001);
    checks++;
    if (ena !== 1'b1 || wea !== 1'b1 || addra !== 16'h4000 || dina !== 32'h1) begin
      errors++;
      $display("FAIL b2b_ctrl got ena=%b wea=%b addra=%h dina=%h exp 1 1 4000 1",
               ena, wea, addra, dina);
    end
    // Present the next command immediately; it must wait for the gap cycle.
    cmd_valid = 1'b1;
    cmd_op    = OP_WR_W;
    cmd_data  = 32'h00FF_0102;
    step();
    checks++;
    if (ena !== 1'b0 || trigger !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got ena=%b trig=%b ready=%b exp 0 1 1", ena, trigger, cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (ena !== 1'b1 || wea !== 1'b1 || addra !== 16'h2000 ||
        dina !== 32'h00FF_0102 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wr_w got ena=%b wea=%b addra=%h dina=%h trig=%b exp 1 1 2000 00ff0102 0",
               ena, wea, addra, dina, trigger);
    end
    step();
    checks++;
    if (ena !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got ena=%b ready=%b exp 0 1", ena, cmd_ready);
    end
  endtask

  task automatic test_read_result();
    rd_q.push_back(32'hFFFF_FFF6);
    issue(OP_RD_RESULT, 32'hAAAA_AAAA);
    checks++;
    if (ena !== 1'b1 || wea !== 1'b0 || addra !== 16'h6000 || dina !== 32'h0) begin
      errors++;
      $display("FAIL rd_bus got ena=%b wea=%b addra=%h dina=%h exp 1 0 6000 0",
               ena, wea, addra, dina);
    end
    step();
    checks++;
    if (ena !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_cap got ena=%b rv=%b exp 0 0", ena, rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFF6 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp got rv=%b rd=%h re=%b exp 1 fffffff6 0", rsp_valid, rsp_data, rsp_err);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_no_bypass got ready=%b exp 0", cmd_ready);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done got rv=%b ready=%b exp 0 1", rsp_valid, cmd_ready);
    end
  endtask

  // Runs one poll command and checks read spacing, address and response.
  task automatic run_poll(input op_e op, input logic [15:0] exp_addr,
                          input int exp_reads, input logic [31:0] exp_data,
                          input logic exp_err);
    int rd_cyc[$];
    int k = 1;
    int rsp_cyc = -1;
    issue(op, 32'h0);
    for (int i = 0; i < 60 && rsp_cyc < 0; i++) begin
      if (ena && !wea) begin
        rd_cyc.push_back(k);
        checks++;
        if (addra !== exp_addr) begin
          errors++;
          $display("FAIL poll_addr got %h exp %h", addra, exp_addr);
        end
      end
      if (rsp_valid) rsp_cyc = k;
      else begin
        step();
        k++;
      end
    end
    checks++;
    if (rd_cyc.size() != exp_reads) begin
      errors++;
      $display("FAIL poll_reads got %0d exp %0d", rd_cyc.size(), exp_reads);
    end
    for (int j = 0; j < rd_cyc.size(); j++) begin
      checks++;
      if (rd_cyc[j] != 2 * j + 1) begin
        errors++;
        $display("FAIL poll_spacing read %0d got cycle %0d exp %0d", j, rd_cyc[j], 2 * j + 1);
      end
    end
    checks++;
    if (rsp_cyc != 3 + 2 * (exp_reads - 1)) begin
      errors++;
      $display("FAIL poll_latency got %0d exp %0d", rsp_cyc, 3 + 2 * (exp_reads - 1));
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL poll_rsp got rv=%b rd=%h re=%b exp 1 %h %b",
               rsp_valid, rsp_data, rsp_err, exp_data, exp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL poll_done got rv=%b ready=%b exp 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_poll_valid();
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h1);
    run_poll(OP_POLL_VALID, 16'h7000, 4, 32'h1, 1'b0);
  endtask

  task automatic test_poll_timeout();
    rd_q.delete();
    run_poll(OP_POLL_DONE, 16'h5000, POLL_MAX + 1, 32'h0, 1'b1);
  endtask

  task automatic test_rsp_stall();
    rd_q.push_back(32'h1234_5678);
    issue(OP_RD_DONE, 32'h0);
    checks++;
    if (addra !== 16'h5000 || ena !== 1'b1) begin
      errors++;
      $display("FAIL stall_addr got addra=%h ena=%b exp 5000 1", addra, ena);
    end
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678 || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || ena !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got rv=%b rd=%h re=%b ready=%b ena=%b exp 1 12345678 0 0 0",
                 i, rsp_valid, rsp_data, rsp_err, cmd_ready, ena);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got rv=%b ready=%b exp 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    rd_q.push_back(32'hDEAD_BEEF);
    issue(OP_RD_RESULT, 32'h0);
    checks++;
    if (ena !== 1'b1 || wea !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre got ena=%b wea=%b exp 1 0", ena, wea);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ena !== 1'b0 || wea !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got ena=%b wea=%b busy=%b exp 0 0 0", ena, wea, busy);
    end
    step();
    step();
    rst = 1'b0;
    rd_q.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || ena !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_after cyc %0d got rv=%b ena=%b ready=%b exp 0 0 1",
                 i, rsp_valid, ena, cmd_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_img();
    test_back_to_back();
    test_read_result();
    test_poll_valid();
    test_poll_timeout();
    test_rsp_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/npu_host_master.md
# npu_host_master

Bus initiator that drives the NPU's BRAM-style host port (`ena`/`wea`/`addra`/`dina`/`douta`) from a simple command stream. Each command becomes exactly one write transaction or one or more read transactions. Read data is returned on a response handshake. Polling commands spin on the NPU `valid`/`done` flag registers with a bounded retry count. The block sits between a sequencer or CPU-side controller and the `npu` slave, replacing hand-written software bus toggling.

## Interface
- `POLL_MAX`, 1023: maximum retries after the first poll read; `POLL_MAX+1` reads total before timeout.
- `ADDR_W`, 16: width of `addra`.
- `DATA_W`, 32: width of `dina`, `douta`, `cmd_data` and `rsp_data`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  3  opcode, see Operation.
- `cmd_data`  in  32  write payload; ignored for reads.
- `rsp_valid`  out  1  read result present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  32  captured `douta`.
- `rsp_err`  out  1  poll timed out.
- `busy`  out  1  state ≠ IDLE.
- `ena`, `wea`  out  1 each  host port enables.
- `addra`  out  16  address; only `[14:12]` (sel) is nonzero.
- `dina`  out  32  write data.
- `douta`  in  32  NPU read data, registered by the slave.

## Operation
Opcodes (`cmd_op` → sel → action):
- 0 `WR_IMG` → 1 → write.
- 1 `WR_W` → 2 → write.
- 2 `WR_FCN` → 3 → write.
- 3 `CTRL` → 4 → write.
- 4 `RD_DONE` → 5 → single read.
- 5 `RD_RESULT` → 6 → single read.
- 6 `POLL_VALID` → 7 → poll.
- 7 `POLL_DONE` → 5 → poll.

Address and data:
- `addra = {1'b0, sel, 12'h000}`.
- Writes drive `dina = cmd_data`; reads drive `dina = 0`.

FSM states:
- IDLE: `cmd_ready = 1` and `ena = 0`. On accept, go to WR for a write, else RD; clear the poll counter.
- WR: one bus cycle with `ena = 1`, `wea = 1`; then IDLE. Writes produce no response.
- RD: one bus cycle with `ena = 1`, `wea = 0`; then CAP.
- CAP: `ena = 0`; `douta` is valid in this cycle.
  - Single read: capture `rsp_data`, go to RSP.
  - Poll with `douta[0] = 1`: capture, `rsp_err = 0`, go to RSP.
  - Poll with `douta[0] = 0` and counter < `POLL_MAX`: increment the counter, go to RD.
  - Poll with `douta[0] = 0` and counter = `POLL_MAX`: capture the last `douta`, `rsp_err = 1`, go to RSP.
- RSP: hold `rsp_valid = 1` with `rsp_data`/`rsp_err` stable until `rsp_ready`; then IDLE.

Rules:
- Every transaction is followed by at least one `ena = 0` cycle (IDLE or CAP). The NPU clears its CTRL pulse bits (trigger, next_state, clears) only on cycles with no access, so back-to-back bus cycles are forbidden.
- Commands are strictly in order. No new command is accepted while a response is pending.

Reset values and reset behaviour:
- All outputs are 0 during and after reset: `ena`, `wea`, `addra`, `dina`, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`.
- `cmd_ready` is 1 after reset release.
- The state returns to IDLE and the poll counter clears.
- Reset mid-transaction drops the command and any pending response; `ena` falls immediately (asynchronously).

## Timing
- All bus outputs are registered and driven in the cycle after the deciding edge.
- Write: accepted at edge 0, bus active in cycle 1, `cmd_ready` high again in cycle 2. Throughput is one write per 2 cycles.
- Read: accepted at edge 0, bus read in cycle 1, `douta` sampled at the end of cycle 2, `rsp_valid` high from cycle 3.
  - Accept-to-response latency is 3 cycles, plus 2 cycles per extra poll.
- Poll reads are spaced exactly 2 cycles apart (RD, CAP, RD, …).
- `cmd_ready` is combinational from state only and never depends on `cmd_valid`.
- `rsp_valid` and `rsp_ready` high in the same cycle completes the response. `cmd_ready` rises the next cycle; there is no same-cycle bypass.

## Structure
- `npu_host_pkg` holds:
  - the `op_e` enum (8 opcodes);
  - sel constants `SEL_IMG = 1`, `SEL_W = 2`, `SEL_FCN = 3`, `SEL_CTRL = 4`, `SEL_DONE = 5`, `SEL_RESULT = 6`, `SEL_VALID = 7`;
  - CTRL bit positions: trigger 0, next_state 1, pe_clear 2, img_clear 3, w_clear 4, pack_clear 5;
  - the `state_e` enum.
- Single module; no sub-module. The poll counter is `$clog2(POLL_MAX+1)` bits wide.

## Test plan
- `WR_IMG`, `cmd_data = 0x00030201` → in cycle 1: `ena = 1`, `wea = 1`, `addra = 0x1000`, `dina = 0x00030201`. Cycle 2: `ena = 0`, `cmd_ready = 1`. No `rsp_valid`.
- `CTRL 0x1` then immediately `WR_W 0x00FF0102` → bus shows `0x4000` write, one `ena = 0` cycle, then `0x2000` write. The slave model's trigger is high for exactly the gap cycle.
- `RD_RESULT`, model `douta = 0xFFFFFFF6` → read at `addra = 0x6000` in cycle 1. `rsp_valid` in cycle 3 with `rsp_data = 0xFFFFFFF6`, `rsp_err = 0`.
- `POLL_VALID`, model returns 0, 0, 0, 1 → 4 reads at `0x7000` spaced 2 cycles apart. Response `rsp_data = 1`, `rsp_err = 0`.
- `POLL_DONE` with `POLL_MAX = 3`, model always 0 → exactly 4 reads, then `rsp_err = 1`, `rsp_data = 0`.
- `rsp_ready` held low 5 cycles → `rsp_valid`/`rsp_data` stable and `cmd_ready = 0` throughout.
- Reset asserted during an RD bus cycle → `ena` and `wea` drop immediately, no response is produced, and `cmd_ready = 1` after release.
